// File: rtl/issue_scoreboard_pkg.sv
// Shared types and helpers for the in-order issue scoreboard.
package issue_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic [0:0] {
        SB_RUN   = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_e;

    // One-hot clear mask for a writeback that hits a busy register; x0 never clears.
    function automatic logic [NUM_REGS-1:0] wb_clear_mask(
        input logic                  hit,
        input logic [REG_ADDR_W-1:0] addr
    );
        logic [NUM_REGS-1:0] mask;
        mask = '0;
        if (hit && (addr != '0)) begin
            mask[addr] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/sb_busy_table.sv
// Per-register busy bits plus outstanding-write counter, with x0-masked lookup ports.
module sb_busy_table
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [NUM_REGS-1:0]   hide_mask,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rd_busy,
    output logic                  clr_hit,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic [CNT_W-1:0]      outstanding
);

    logic                set_hit;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] lookup;

    assign set_hit  = set_en && (set_addr != '0);
    assign clr_hit  = clr_en && (clr_addr != '0) && busy_vec[clr_addr];
    assign clr_mask = wb_clear_mask(clr_hit, clr_addr);

    always_comb begin
        set_mask = '0;
        if (set_hit) begin
            set_mask[set_addr] = 1'b1;
        end
    end

    // Lookups see the registered table minus any registers hidden by the caller.
    assign lookup   = busy_vec & ~hide_mask;
    assign rs1_busy = (rs1_addr != '0) && lookup[rs1_addr];
    assign rs2_busy = (rs2_addr != '0) && lookup[rs2_addr];
    assign rd_busy  = (rd_addr  != '0) && lookup[rd_addr];

    // Clear before set so a same-register clear+set leaves the bit busy and the count flat.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec    <= '0;
            outstanding <= '0;
        end else begin
            busy_vec    <= (busy_vec & ~clr_mask) | set_mask;
            outstanding <= outstanding + CNT_W'(set_hit) - CNT_W'(clr_hit);
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue controller: RAW/WAW hazard stall, in-flight cap, drain before serializing ops.
// Define ISSUE_SCOREBOARD_WB_BYPASS_EN to let same-cycle writebacks release stalls.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid_i,
    output logic                  dec_ready_o,
    input  logic [REG_ADDR_W-1:0] dec_rs1_addr_i,
    input  logic                  dec_uses_rs1_i,
    input  logic [REG_ADDR_W-1:0] dec_rs2_addr_i,
    input  logic                  dec_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] dec_rd_addr_i,
    input  logic                  dec_reg_write_en_i,
    input  logic                  dec_serialize_i,
    output logic                  iss_valid_o,
    input  logic                  iss_ready_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
    output logic [NUM_REGS-1:0]   busy_vec_o,
    output logic [CNT_W-1:0]      outstanding_o,
    output logic                  wb_err_o
);

    sb_state_e           state;
    logic                writer;
    logic                wb_elig;
    logic                clr_hit;
    logic                rs1_busy;
    logic                rs2_busy;
    logic                rd_busy;
    logic                hazard;
    logic                cap_full;
    logic                ser_block;
    logic                fire;
    logic [NUM_REGS-1:0] hide_mask;
    logic [CNT_W-1:0]    eff_cnt;

    assign writer  = dec_reg_write_en_i && (dec_rd_addr_i != '0);
    assign wb_elig = wb_valid_i && (wb_rd_addr_i != '0);

`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
    assign hide_mask = wb_clear_mask(clr_hit, wb_rd_addr_i);
    assign eff_cnt   = outstanding_o - CNT_W'(clr_hit);
`else
    assign hide_mask = '0;
    assign eff_cnt   = outstanding_o;
`endif

    assign hazard    = (dec_uses_rs1_i && rs1_busy) || (dec_uses_rs2_i && rs2_busy) || (writer && rd_busy);
    assign cap_full  = writer && (eff_cnt == CNT_W'(MAX_INFLIGHT));
    assign ser_block = dec_serialize_i && (outstanding_o != '0);

    assign iss_valid_o = dec_valid_i && (state == SB_RUN) && !hazard && !cap_full && !ser_block;
    assign dec_ready_o = iss_valid_o && iss_ready_i;
    assign fire        = dec_valid_i && dec_ready_o;

    sb_busy_table #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CNT_W)
    ) u_busy_table (
        .clk         (clk),
        .rst         (rst),
        .set_en      (fire && writer),
        .set_addr    (dec_rd_addr_i),
        .clr_en      (wb_elig),
        .clr_addr    (wb_rd_addr_i),
        .hide_mask   (hide_mask),
        .rs1_addr    (dec_rs1_addr_i),
        .rs2_addr    (dec_rs2_addr_i),
        .rd_addr     (dec_rd_addr_i),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rd_busy     (rd_busy),
        .clr_hit     (clr_hit),
        .busy_vec    (busy_vec_o),
        .outstanding (outstanding_o)
    );

    // Drain FSM: only RUN can enter DRAIN; exit once all writes have retired.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SB_RUN;
        end else begin
            case (state)
                SB_RUN:   if (dec_valid_i && ser_block) state <= SB_DRAIN;
                SB_DRAIN: if (eff_cnt == '0)            state <= SB_RUN;
                default:                                state <= SB_RUN;
            endcase
        end
    end

    // Sticky flag for a writeback that finds no pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_err_o <= 1'b0;
        end else if (wb_elig && !clr_hit) begin
            wb_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: expected issues queued by stimulus, popped by a monitor.
module tb_issue_scoreboard;

    localparam int unsigned MAX_INFLIGHT = 4;
    localparam int unsigned CNT_W        = 3;

`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
    localparam int WB_LAT    = 0;
    localparam int DRAIN_LAT = 1;
`else
    localparam int WB_LAT    = 1;
    localparam int DRAIN_LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             dec_valid_i;
    logic             dec_ready_o;
    logic [4:0]       dec_rs1_addr_i;
    logic             dec_uses_rs1_i;
    logic [4:0]       dec_rs2_addr_i;
    logic             dec_uses_rs2_i;
    logic [4:0]       dec_rd_addr_i;
    logic             dec_reg_write_en_i;
    logic             dec_serialize_i;
    logic             iss_valid_o;
    logic             iss_ready_i;
    logic             wb_valid_i;
    logic [4:0]       wb_rd_addr_i;
    logic [31:0]      busy_vec_o;
    logic [CNT_W-1:0] outstanding_o;
    logic             wb_err_o;

    typedef struct {
        int         cyc;
        logic [4:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    issue_scoreboard #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .dec_valid_i        (dec_valid_i),
        .dec_ready_o        (dec_ready_o),
        .dec_rs1_addr_i     (dec_rs1_addr_i),
        .dec_uses_rs1_i     (dec_uses_rs1_i),
        .dec_rs2_addr_i     (dec_rs2_addr_i),
        .dec_uses_rs2_i     (dec_uses_rs2_i),
        .dec_rd_addr_i      (dec_rd_addr_i),
        .dec_reg_write_en_i (dec_reg_write_en_i),
        .dec_serialize_i    (dec_serialize_i),
        .iss_valid_o        (iss_valid_o),
        .iss_ready_i        (iss_ready_i),
        .wb_valid_i         (wb_valid_i),
        .wb_rd_addr_i       (wb_rd_addr_i),
        .busy_vec_o         (busy_vec_o),
        .outstanding_o      (outstanding_o),
        .wb_err_o           (wb_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_until(input int e);
        while (cyc <= e) step();
    endtask

    task automatic drive_dec(input logic v, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2,
                             input logic [4:0] rd, input logic we, input logic ser);
        dec_valid_i        = v;
        dec_rs1_addr_i     = rs1;
        dec_uses_rs1_i     = u1;
        dec_rs2_addr_i     = rs2;
        dec_uses_rs2_i     = u2;
        dec_rd_addr_i      = rd;
        dec_reg_write_en_i = we;
        dec_serialize_i    = ser;
    endtask

    task automatic idle_dec();
        drive_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drive_wb(input logic v, input logic [4:0] a);
        wb_valid_i   = v;
        wb_rd_addr_i = a;
    endtask

    task automatic expect_issue(input int c, input logic [4:0] rd);
        exp_q.push_back('{c, rd});
    endtask

    // Monitor: every accepted instruction must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1) begin
            check("popcount", 32'(outstanding_o), 32'($countones(busy_vec_o)));
            check("x0_never_busy", 32'(busy_vec_o[0]), 32'd0);
            if (dec_valid_i && dec_ready_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: issued rd=%0d at cycle %0d, expected no issue",
                             dec_rd_addr_i, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_cycle", 32'(cyc), 32'(e.cyc));
                    check("issue_rd", 32'(dec_rd_addr_i), 32'(e.rd));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int n;
        rst         = 1'b1;
        iss_ready_i = 1'b1;
        idle_dec();
        drive_wb(1'b0, 5'd0);
        step();
        step();
        check("rst_busy", busy_vec_o, 32'd0);
        check("rst_out", 32'(outstanding_o), 32'd0);
        check("rst_wb_err", 32'(wb_err_o), 32'd0);
        check("rst_iss_valid", 32'(iss_valid_o), 32'd0);
        rst = 1'b0;
        step();

        // add x5,x1,x2 issues immediately
        drive_dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        expect_issue(cyc, 5'd5);
        #1;
        check("add_iss_valid", 32'(iss_valid_o), 32'd1);
        step();
        idle_dec();
        check("add_busy", busy_vec_o, 32'h0000_0020);
        check("add_out", 32'(outstanding_o), 32'd1);

        // RAW on x5, released by its writeback
        drive_dec(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        #1;
        check("raw_stall", 32'(iss_valid_o), 32'd0);
        step();
        n = cyc;
        drive_wb(1'b1, 5'd5);
        expect_issue(n + WB_LAT, 5'd6);
        step();
        drive_wb(1'b0, 5'd0);
        hold_until(n + WB_LAT);
        idle_dec();
        check("raw_busy", busy_vec_o, 32'h0000_0040);
        check("raw_out", 32'(outstanding_o), 32'd1);
        drive_wb(1'b1, 5'd6);
        step();
        drive_wb(1'b0, 5'd0);
        check("raw_clear_busy", busy_vec_o, 32'd0);
        check("raw_clear_out", 32'(outstanding_o), 32'd0);

        // fill to the in-flight cap, fifth writer waits for one writeback
        for (int k = 1; k <= 4; k++) begin
            drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(k), 1'b1, 1'b0);
            expect_issue(cyc, 5'(k));
            step();
        end
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        #1;
        check("cap_stall", 32'(iss_valid_o), 32'd0);
        check("cap_out_full", 32'(outstanding_o), 32'd4);
        step();
        n = cyc;
        drive_wb(1'b1, 5'd1);
        expect_issue(n + WB_LAT, 5'd6);
        step();
        drive_wb(1'b0, 5'd0);
        hold_until(n + WB_LAT);
        idle_dec();
        check("cap_busy", busy_vec_o, 32'h0000_005C);
        check("cap_out", 32'(outstanding_o), 32'd4);

        // serialize with two writes pending: drain then issue
        drive_wb(1'b1, 5'd2);
        step();
        drive_wb(1'b1, 5'd3);
        step();
        drive_wb(1'b0, 5'd0);
        check("ser_pre_busy", busy_vec_o, 32'h0000_0050);
        check("ser_pre_out", 32'(outstanding_o), 32'd2);
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        #1;
        check("ser_stall", 32'(iss_valid_o), 32'd0);
        step();
        drive_wb(1'b1, 5'd4);
        #1;
        check("drain_stall", 32'(iss_valid_o), 32'd0);
        step();
        n = cyc;
        drive_wb(1'b1, 5'd6);
        expect_issue(n + DRAIN_LAT, 5'd0);
        step();
        drive_wb(1'b0, 5'd0);
        check("drain_out", 32'(outstanding_o), 32'd0);
        check("drain_busy", busy_vec_o, 32'd0);
        hold_until(n + DRAIN_LAT);
        idle_dec();

        // x0 destination and x0 writeback are ignored; stray writeback is sticky
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        drive_wb(1'b1, 5'd0);
        expect_issue(cyc, 5'd0);
        step();
        idle_dec();
        drive_wb(1'b0, 5'd0);
        check("x0_busy", busy_vec_o, 32'd0);
        check("x0_out", 32'(outstanding_o), 32'd0);
        check("x0_wb_err", 32'(wb_err_o), 32'd0);
        drive_wb(1'b1, 5'd7);
        step();
        drive_wb(1'b0, 5'd0);
        check("wb_err_set", 32'(wb_err_o), 32'd1);
        step();
        step();
        check("wb_err_sticky", 32'(wb_err_o), 32'd1);

        // reset while draining with three writes pending
        for (int k = 1; k <= 3; k++) begin
            drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(k), 1'b1, 1'b0);
            expect_issue(cyc, 5'(k));
            step();
        end
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        #1;
        check("ser2_stall", 32'(iss_valid_o), 32'd0);
        step();
        idle_dec();
        step();
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check("drain_hold", 32'(iss_valid_o), 32'd0);
        check("drain_hold_out", 32'(outstanding_o), 32'd3);
        step();
        idle_dec();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_busy", busy_vec_o, 32'd0);
        check("rst2_out", 32'(outstanding_o), 32'd0);
        check("rst2_wb_err", 32'(wb_err_o), 32'd0);
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_issue(cyc, 5'd0);
        #1;
        check("rst2_run", 32'(iss_valid_o), 32'd1);
        step();
        idle_dec();
        drive_wb(1'b1, 5'd1);
        step();
        drive_wb(1'b0, 5'd0);
        check("post_rst_wb_err", 32'(wb_err_o), 32'd1);
        step();
        step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
